// File: rtl/tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tx_arbiter
// Description : Round-robin arbiter feeding N byte streams into one UART
//               transmitter; optional message lock (TX_ARBITER_LOCK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tx_arbiter #(
    parameter int                NUM_REQ      = 4,
    parameter int                WIDTH        = 8,
    parameter logic [WIDTH-1:0]  EOL_BYTE     = 'h0A,
    parameter int                LOCK_TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [WIDTH-1:0]            tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        locked
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_XFER = 1'b1
    } state_t;

    state_t             state_q,    state_d;
    logic [IDW-1:0]     rr_ptr_q,   rr_ptr_d;
    logic [WIDTH-1:0]   tx_data_q,  tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic [IDW-1:0]     grant_q,    grant_d;

    logic [WIDTH-1:0]   w_bytes [NUM_REQ];
    logic               w_found;
    logic [IDW-1:0]     w_win;
    logic [IDW-1:0]     w_next_ptr;

`ifdef TX_ARBITER_LOCK_EN
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);
    logic               locked_q,   locked_d;
    logic [CW-1:0]      cnt_q,      cnt_d;
`else
    logic               w_unused_cfg;
    assign w_unused_cfg = (^EOL_BYTE) ^ (LOCK_TIMEOUT > 0);
`endif

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign w_bytes[i] = req_data[i*WIDTH +: WIDTH];
    end

    // Search upward from rr_ptr; index arithmetic carries one extra bit so
    // the explicit modulo also works for non-power-of-two NUM_REQ.
    always_comb begin
        logic [IDW:0] sum;
        w_found = 1'b0;
        w_win   = '0;
        sum     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NUM_REQ)) begin
                sum = sum - (IDW+1)'(NUM_REQ);
            end
            if (!w_found && req_valid[sum[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = sum[IDW-1:0];
            end
        end
`ifdef TX_ARBITER_LOCK_EN
        if (locked_q) begin
            w_found = req_valid[grant_q];
            w_win   = grant_q;
        end
`endif
    end

    assign w_next_ptr = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    assign req_ready = (rst_n && (state_q == S_IDLE) && w_found)
                     ? (NUM_REQ'(1) << w_win) : '0;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        grant_d    = grant_q;
`ifdef TX_ARBITER_LOCK_EN
        locked_d   = locked_q;
        cnt_d      = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    tx_data_d  = w_bytes[w_win];
                    grant_d    = w_win;
                    tx_valid_d = 1'b1;
                    state_d    = S_XFER;
`ifdef TX_ARBITER_LOCK_EN
                    cnt_d      = '0;
                end else if (locked_q && !req_valid[grant_q]) begin
                    // Owner went quiet mid-message: give up the lock eventually.
                    if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                        locked_d = 1'b0;
                        rr_ptr_d = w_next_ptr;
                        cnt_d    = '0;
                    end else begin
                        cnt_d    = cnt_q + 1'b1;
                    end
`endif
                end
            end
            S_XFER: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
`ifdef TX_ARBITER_LOCK_EN
                    cnt_d      = '0;
                    if (tx_data_q == EOL_BYTE) begin
                        locked_d = 1'b0;
                        rr_ptr_d = w_next_ptr;
                    end else begin
                        locked_d = 1'b1;
                    end
`else
                    rr_ptr_d   = w_next_ptr;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            grant_q    <= '0;
`ifdef TX_ARBITER_LOCK_EN
            locked_q   <= 1'b0;
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            grant_q    <= grant_d;
`ifdef TX_ARBITER_LOCK_EN
            locked_q   <= locked_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign grant_id = grant_q;
`ifdef TX_ARBITER_LOCK_EN
    assign locked   = locked_q;
`else
    assign locked   = 1'b0;
`endif

endmodule
`default_nettype wire
